mips_fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the next-generation MIPS core, replacing the single-cycle PC register, PC+4 adder and branch/jump next-PC muxes. It owns the program counter and issues word fetches to an instruction memory over a request/grant/response handshake. Fetched words are buffered with their PC in a small prefetch FIFO, and the unit accepts a one-cycle redirect (taken branch, J/JAL/JR) from the execute stage. Decode consumes instructions through a valid/ready interface, so variable-latency memory and decode stalls are absorbed here.

---
 rtl/mips_fetch_pkg.sv | 17 +
 rtl/mips_fetch_unit_if.sv | 28 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/mips_fetch_unit.sv | 91 +++++++++
 tb/tb_mips_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch front end.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_STEP = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Instruction-memory request/grant/response bus between the fetch unit and memory.
interface mips_fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();

  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_gnt;
  logic                  imem_rvalid;
  logic [31:0]           imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush, occupancy count and a head output that reads zero when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             pop_ok;

  always_comb begin
    pop_ok   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok) rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push_i) - CntW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i && !reset) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign valid_o = (count_q != '0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues credit-limited word fetches and buffers
// {pc, instr} pairs for decode; a redirect flushes the buffer and retargets the PC.
module mips_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0040_0000,
  parameter int unsigned           FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  mips_fetch_unit_if.master               imem,
  input  logic                            redirect_valid,
  input  logic [ADDR_WIDTH-1:0]           redirect_target,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [31:0]                     out_instr,
  output logic [ADDR_WIDTH-1:0]           out_pc,
  output logic [ADDR_WIDTH-1:0]           out_pc4,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int unsigned EntryW = ADDR_WIDTH + 32;

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] issued_pc_q, issued_pc_d;
  logic                  in_flight;
  logic                  credit;
  logic                  req;
  logic                  push;
  logic [EntryW-1:0]     head;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    issued_pc_d = issued_pc_q;
    // Only a WAIT response will land in the FIFO; a FLUSH response is discarded.
    in_flight   = (state_q == WAIT);
    credit      = (32'(fifo_count) + 32'(in_flight)) < FIFO_DEPTH;
    req         = !reset && !redirect_valid && credit &&
                  ((state_q == ISSUE) || imem.imem_rvalid);
    push        = !reset && !redirect_valid && in_flight && imem.imem_rvalid;

    if (redirect_valid) begin
      fetch_pc_d = redirect_target & ~ADDR_WIDTH'(3);
      state_d    = (state_q != ISSUE && !imem.imem_rvalid) ? FLUSH : ISSUE;
    end else if (req && imem.imem_gnt) begin
      fetch_pc_d  = fetch_pc_q + ADDR_WIDTH'(PC_STEP);
      issued_pc_d = fetch_pc_q;
      state_d     = WAIT;
    end else if (state_q != ISSUE && imem.imem_rvalid) begin
      state_d = ISSUE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ISSUE;
      fetch_pc_q  <= RESET_PC;
      issued_pc_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = fetch_pc_q;

  sync_fifo #(
    .WIDTH (EntryW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect_valid),
    .push_i  (push),
    .wdata_i ({issued_pc_q, imem.imem_rdata}),
    .pop_i   (out_ready),
    .valid_o (out_valid),
    .head_o  (head),
    .count_o (fifo_count)
  );

  assign out_pc    = head[EntryW-1:32];
  assign out_instr = head[31:0];
  assign out_pc4   = out_pc + ADDR_WIDTH'(PC_STEP);

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: cycle table for streaming/backpressure plus sequences
// for fill/drain, grant stall, redirects, PC wrap and mid-run reset.
module tb_mips_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        gnt_en;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_fail = 0;
  int lat = 1;
  int n_grants = 0;

  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = '0;

  always #5 clk = ~clk;

  mips_fetch_unit_if #(.ADDR_WIDTH(32)) imem ();

  assign imem.imem_gnt    = gnt_en;
  assign imem.imem_rvalid = mem_rvalid;
  assign imem.imem_rdata  = mem_rdata;

  mips_fetch_unit #(
    .ADDR_WIDTH (32),
    .RESET_PC   (32'h0040_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem            (imem),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_pc4         (out_pc4),
    .fifo_count      (fifo_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // Memory model: response exactly lat cycles after grant, dropped on reset.
  always @(posedge clk) begin
    if (reset) begin
      pend       <= 1'b0;
      mem_rvalid <= 1'b0;
    end else begin
      mem_rvalid <= 1'b0;
      if (pend) begin
        if (cnt == 1) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= mem_word(paddr);
          pend       <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (imem.imem_req && imem.imem_gnt) begin
        n_grants <= n_grants + 1;
        if (lat == 1) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= mem_word(imem.imem_addr);
        end else begin
          pend  <= 1'b1;
          cnt   <= lat - 1;
          paddr <= imem.imem_addr;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic wait_valid(input string name);
    int i;
    i = 0;
    while (!out_valid && i < 20) begin
      @(negedge clk);
      #1;
      i++;
    end
    check(name, 32'(out_valid), 32'd1);
  endtask

  typedef struct {
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    int          count;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int exp_pc;
    int got;
    int g0;

    vecs[0] = '{1'b1, 1'b1, 32'h0040_0000, 1'b0, 32'h0,          0};
    vecs[1] = '{1'b1, 1'b1, 32'h0040_0004, 1'b0, 32'h0,          0};
    vecs[2] = '{1'b1, 1'b1, 32'h0040_0008, 1'b1, 32'h0040_0000, 1};
    vecs[3] = '{1'b1, 1'b1, 32'h0040_000C, 1'b1, 32'h0040_0004, 1};
    vecs[4] = '{1'b1, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0008, 1};
    vecs[5] = '{1'b0, 1'b1, 32'h0040_0014, 1'b1, 32'h0040_000C, 1};
    vecs[6] = '{1'b0, 1'b1, 32'h0040_0018, 1'b1, 32'h0040_000C, 2};
    vecs[7] = '{1'b1, 1'b0, 32'h0040_001C, 1'b1, 32'h0040_000C, 3};
    vecs[8] = '{1'b1, 1'b1, 32'h0040_001C, 1'b1, 32'h0040_0010, 3};
    vecs[9] = '{1'b1, 1'b1, 32'h0040_0020, 1'b1, 32'h0040_0014, 2};

    out_ready = 1'b1;
    gnt_en = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = '0;

    // Reset values, observed while reset is still asserted.
    @(negedge clk);
    check("rst_req", 32'(imem.imem_req), 32'd0);
    check("rst_addr", imem.imem_addr, 32'h0040_0000);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_pc4", out_pc4, 32'h4);
    check("rst_count", 32'(fifo_count), 32'd0);
    reset = 1'b0;
    #1;

    // Streaming and backpressure table, gnt=1, k=1.
    for (int r = 0; r < 10; r++) begin
      out_ready = vecs[r].ready;
      check($sformatf("tbl%0d_req", r), 32'(imem.imem_req), 32'(vecs[r].req));
      if (vecs[r].req) check($sformatf("tbl%0d_addr", r), imem.imem_addr, vecs[r].addr);
      check($sformatf("tbl%0d_valid", r), 32'(out_valid), 32'(vecs[r].valid));
      check($sformatf("tbl%0d_count", r), 32'(fifo_count), 32'(vecs[r].count));
      if (vecs[r].valid) begin
        check($sformatf("tbl%0d_pc", r), out_pc, vecs[r].pc);
        check($sformatf("tbl%0d_instr", r), out_instr, mem_word(vecs[r].pc));
        check($sformatf("tbl%0d_pc4", r), out_pc4, vecs[r].pc + 32'd4);
      end
      @(negedge clk);
      #1;
    end

    // Fill with decode stalled: exactly FIFO_DEPTH fetches, then drain in order.
    out_ready = 1'b0;
    do_reset();
    g0 = n_grants;
    repeat (12) @(negedge clk);
    #1;
    check("fill_count", 32'(fifo_count), 32'd4);
    check("fill_req", 32'(imem.imem_req), 32'd0);
    check("fill_grants", 32'(n_grants - g0), 32'd4);
    check("fill_head", out_pc, 32'h0040_0000);
    out_ready = 1'b1;
    exp_pc = 32'h0040_0000;
    got = 0;
    for (int i = 0; i < 60 && got < 8; i++) begin
      if (out_valid) begin
        check("drain_pc", out_pc, exp_pc);
        check("drain_instr", out_instr, mem_word(exp_pc));
        exp_pc += 4;
        got++;
      end
      @(negedge clk);
      #1;
    end
    check("drain_total", 32'(got), 32'd8);

    // Grant withheld for three cycles: address holds, PC advances once.
    gnt_en = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      check("stall_req", 32'(imem.imem_req), 32'd1);
      check("stall_addr", imem.imem_addr, 32'h0040_0000);
      @(negedge clk);
      #1;
    end
    gnt_en = 1'b1;
    @(negedge clk);
    #1;
    check("stall_next_addr", imem.imem_addr, 32'h0040_0004);
    check("stall_next_req", 32'(imem.imem_req), 32'd1);

    // Redirect while waiting on a k=3 response: stale response discarded in FLUSH.
    lat = 3;
    do_reset();
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_target = 32'h0040_0103;
    #1;
    check("rdw_req", 32'(imem.imem_req), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("rdw_valid", 32'(out_valid), 32'd0);
    check("rdw_count", 32'(fifo_count), 32'd0);
    check("rdw_flush_req", 32'(imem.imem_req), 32'd0);
    @(negedge clk);
    #1;
    check("rdw_new_req", 32'(imem.imem_req), 32'd1);
    check("rdw_new_addr", imem.imem_addr, 32'h0040_0100);
    wait_valid("rdw_wait");
    check("rdw_pc", out_pc, 32'h0040_0100);
    check("rdw_instr", out_instr, mem_word(32'h0040_0100));
    lat = 1;

    // Redirect coinciding with rvalid and a pop.
    do_reset();
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_target = 32'h0050_0000;
    #1;
    check("rdv_req", 32'(imem.imem_req), 32'd0);
    check("rdv_head", out_pc, 32'h0040_0000);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("rdv_valid", 32'(out_valid), 32'd0);
    check("rdv_count", 32'(fifo_count), 32'd0);
    check("rdv_new_req", 32'(imem.imem_req), 32'd1);
    check("rdv_new_addr", imem.imem_addr, 32'h0050_0000);
    wait_valid("rdv_wait");
    check("rdv_pc", out_pc, 32'h0050_0000);

    // PC wrap-around past the top of the address space.
    do_reset();
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    #1;
    check("wrap_rd_req", 32'(imem.imem_req), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("wrap_addr0", imem.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    #1;
    check("wrap_addr1", imem.imem_addr, 32'h0000_0000);
    check("wrap_req1", 32'(imem.imem_req), 32'd1);
    @(negedge clk);
    #1;
    check("wrap_valid", 32'(out_valid), 32'd1);
    check("wrap_pc", out_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", out_pc4, 32'h0000_0000);

    // Reset in the middle of filling the FIFO.
    out_ready = 1'b0;
    do_reset();
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_req", 32'(imem.imem_req), 32'd0);
    check("mid_rst_addr", imem.imem_addr, 32'h0040_0000);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_pc", out_pc, 32'h0);
    check("mid_rst_instr", out_instr, 32'h0);
    check("mid_rst_pc4", out_pc4, 32'h4);
    reset = 1'b0;
    #1;
    check("post_rst_req", 32'(imem.imem_req), 32'd1);
    check("post_rst_addr", imem.imem_addr, 32'h0040_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
